// File: rtl/chess_display_scheduler.sv
// ============================================================================
// Module   : chess_display_scheduler
// Purpose  : Round-robin, non-preemptive owner of the single LCD pixel port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chess_display_scheduler #(
  parameter int NUM_TASKS = 3,
  parameter int IDX_W     = 2
) (
  input  logic                   clock,
  input  logic                   resetApp_n,
  input  logic [NUM_TASKS-1:0]   taskReq,
  input  logic [NUM_TASKS-1:0]   taskEnd,
  input  logic [16*NUM_TASKS-1:0] taskPixelData,
  input  logic [8*NUM_TASKS-1:0] taskXAddr,
  input  logic [9*NUM_TASKS-1:0] taskYAddr,
  input  logic                   lcdPixelReady,
  output logic [NUM_TASKS-1:0]   taskReset,
  output logic [NUM_TASKS-1:0]   taskPixelReady,
  output logic                   lcdPixelWrite,
  output logic [15:0]            lcdPixelData,
  output logic [7:0]             lcdXAddr,
  output logic [8:0]             lcdYAddr,
  output logic                   busy,
  output logic [IDX_W-1:0]       activeTask,
  output logic [NUM_TASKS-1:0]   taskDone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_lastGrant;
  logic                 r_pixWrite;
  logic [IDX_W-1:0]     w_pick;
  logic [NUM_TASKS-1:0] w_pickOneHot;
  logic [NUM_TASKS-1:0] w_activeOneHot;
  logic                 w_anyReq;
  logic                 w_endActive;
  logic                 w_finalWrite;

  // Walk offsets from farthest to nearest so the nearest requester after lastGrant wins.
  always_comb begin
    w_pick       = '0;
    w_pickOneHot = '0;
    w_anyReq     = |taskReq;
    for (int off = NUM_TASKS; off >= 1; off--) begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        if (((int'(r_lastGrant) + off == i) || (int'(r_lastGrant) + off == i + NUM_TASKS))
            && taskReq[i]) begin
          w_pick = IDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_TASKS; i++) begin
      w_pickOneHot[i] = (w_pick == IDX_W'(i));
    end
  end

  always_comb begin
    w_activeOneHot = '0;
    w_endActive    = 1'b0;
    lcdPixelData   = '0;
    lcdXAddr       = '0;
    lcdYAddr       = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (activeTask == IDX_W'(i)) begin
        w_activeOneHot[i] = 1'b1;
        w_endActive       = taskEnd[i];
        if (r_state == RUN) begin
          lcdPixelData = taskPixelData[16*i +: 16];
          lcdXAddr     = taskXAddr[8*i +: 8];
          lcdYAddr     = taskYAddr[9*i +: 9];
        end
      end
    end
  end

  // A stale taskEnd is harmless: it only counts alongside a real write.
  assign w_finalWrite   = (r_state == RUN) && r_pixWrite && w_endActive;
  assign taskPixelReady = ((r_state == RUN) && lcdPixelReady && !w_finalWrite)
                          ? w_activeOneHot : '0;
  assign lcdPixelWrite  = r_pixWrite && (r_state == RUN);
  assign busy           = (r_state == RESTART) || (r_state == RUN);

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      r_state     <= IDLE;
      activeTask  <= '0;
      r_lastGrant <= IDX_W'(NUM_TASKS - 1);
      taskReset   <= '0;
      taskDone    <= '0;
      r_pixWrite  <= 1'b0;
    end else begin
      taskReset  <= '0;
      taskDone   <= '0;
      r_pixWrite <= |taskPixelReady;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            activeTask <= w_pick;
            taskReset  <= w_pickOneHot;
            r_state    <= RESTART;
          end
        end
        RESTART: r_state <= RUN;
        RUN: begin
          if (w_finalWrite) begin
            taskDone <= w_activeOneHot;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          r_lastGrant <= activeTask;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chess_display_scheduler.sv
// ============================================================================
// Module   : tb_chess_display_scheduler
// Purpose  : Directed bench for chess_display_scheduler with stub pixel tasks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_chess_display_scheduler;

  localparam int NT = 3;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic resetApp_n;
  logic [NT-1:0] taskReq;
  logic [NT-1:0] setStale;
  logic lcdPixelReady;
  wire  [NT-1:0] taskEnd;
  wire  [16*NT-1:0] taskPixelData;
  wire  [8*NT-1:0] taskXAddr;
  wire  [9*NT-1:0] taskYAddr;
  logic [NT-1:0] taskReset;
  logic [NT-1:0] taskPixelReady;
  logic [NT-1:0] taskDone;
  logic lcdPixelWrite;
  logic [15:0] lcdPixelData;
  logic [7:0] lcdXAddr;
  logic [8:0] lcdYAddr;
  logic busy;
  logic [IW-1:0] activeTask;

  int frameLen [NT];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [NT-1:0] vec; } ev_t;
  typedef struct { int cyc; logic [IW-1:0] tsk; logic [15:0] d; logic [7:0] x; logic [8:0] y; } wr_t;
  ev_t grantQ[$];
  ev_t doneQ[$];
  wr_t writeQ[$];
  int  fwdQ[$];
  logic [NT-1:0] lastGrantVec;

  chess_display_scheduler #(.NUM_TASKS(NT), .IDX_W(IW)) dut (
    .clock(clock), .resetApp_n(resetApp_n), .taskReq(taskReq), .taskEnd(taskEnd),
    .taskPixelData(taskPixelData), .taskXAddr(taskXAddr), .taskYAddr(taskYAddr),
    .lcdPixelReady(lcdPixelReady), .taskReset(taskReset), .taskPixelReady(taskPixelReady),
    .lcdPixelWrite(lcdPixelWrite), .lcdPixelData(lcdPixelData), .lcdXAddr(lcdXAddr),
    .lcdYAddr(lcdYAddr), .busy(busy), .activeTask(activeTask), .taskDone(taskDone)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [15:0] pix(input int i, input int c);
    logic [15:0] tbl [4];
    tbl = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    if (i == 0 && c < 4) return tbl[c];
    return 16'(16'h1000 * (i + 1) + c);
  endfunction

  // Stub tasks: register one pixel per forwarded ready, raise taskEnd with the last one.
  for (genvar g = 0; g < NT; g++) begin : g_stub
    int cnt;
    logic [15:0] dR;
    logic [7:0] xR;
    logic [8:0] yR;
    logic endR;
    always @(posedge clock or negedge resetApp_n) begin
      if (!resetApp_n) begin
        cnt <= 0; dR <= '0; xR <= '0; yR <= '0; endR <= 1'b0;
      end else if (taskReset[g]) begin
        cnt <= 0; dR <= '0; xR <= '0; yR <= '0; endR <= 1'b0;
      end else if (setStale[g]) begin
        endR <= 1'b1;
      end else if (taskPixelReady[g]) begin
        dR   <= pix(g, cnt);
        xR   <= 8'(cnt);
        yR   <= 9'(g);
        endR <= (cnt == frameLen[g] - 1);
        cnt  <= cnt + 1;
      end
    end
    assign taskEnd[g]              = endR;
    assign taskPixelData[16*g +: 16] = dR;
    assign taskXAddr[8*g +: 8]     = xR;
    assign taskYAddr[9*g +: 9]     = yR;
  end

  always @(negedge clock) begin
    if (resetApp_n) begin
      if (taskPixelReady != '0) begin
        checks++;
        if (!$onehot(taskPixelReady) || ((taskPixelReady & ~lastGrantVec) != '0) || !lcdPixelReady) begin
          errors++;
          $display("FAIL pixelReady_onehot cyc=%0d got=%b granted=%b lcdReady=%b",
                   cyc, taskPixelReady, lastGrantVec, lcdPixelReady);
        end
        fwdQ.push_back(cyc);
      end
      if (taskReset != '0) begin
        grantQ.push_back('{cyc, taskReset});
        lastGrantVec = taskReset;
      end
      if (taskDone != '0) doneQ.push_back('{cyc, taskDone});
      if (lcdPixelWrite) writeQ.push_back('{cyc, activeTask, lcdPixelData, lcdXAddr, lcdYAddr});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    resetApp_n = 1'b0;
    taskReq = '0;
    lcdPixelReady = 1'b0;
    setStale = '0;
    for (int i = 0; i < NT; i++) frameLen[i] = 4;
    repeat (2) tick();
    grantQ.delete(); doneQ.delete(); writeQ.delete(); fwdQ.delete();
    lastGrantVec = '0;
    resetApp_n = 1'b1;
  endtask

  // which: 0 grants, 1 writes, 2 done pulses
  task automatic waitQ(input int which, input int n, input int maxCyc, output bit ok);
    int sz;
    ok = 1'b0;
    for (int i = 0; i < maxCyc && !ok; i++) begin
      @(negedge clock);
      #1;
      sz = (which == 0) ? grantQ.size() : (which == 1) ? writeQ.size() : doneQ.size();
      if (sz >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetApp_n = 1'b0;
    taskReq = '1;
    lcdPixelReady = 1'b1;
    setStale = '0;
    for (int i = 0; i < NT; i++) frameLen[i] = 4;
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if ({taskReset, taskPixelReady, taskDone} !== '0) begin
      errors++; $display("FAIL reset_vectors got=%b want=0", {taskReset, taskPixelReady, taskDone});
    end
    checks++;
    if ({lcdPixelWrite, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_write_busy got=%b want=00", {lcdPixelWrite, busy});
    end
    checks++;
    if ({lcdPixelData, lcdXAddr, lcdYAddr} !== '0) begin
      errors++; $display("FAIL reset_mux got=%h want=0", {lcdPixelData, lcdXAddr, lcdYAddr});
    end
    checks++;
    if (activeTask !== 2'd0) begin
      errors++; $display("FAIL reset_activeTask got=%0d want=0", activeTask);
    end
  endtask

  task automatic test_single();
    logic [15:0] expD [4];
    int reqCyc;
    bit ok;
    expD = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    doReset();
    lcdPixelReady = 1'b1;
    taskReq = 3'b001;
    reqCyc = cyc;
    tick();
    taskReq = '0;
    @(negedge clock);
    checks++;
    if ({taskReset, busy} !== 4'b0011) begin
      errors++; $display("FAIL single_restart got=%b want=0011", {taskReset, busy});
    end
    waitQ(2, 1, 40, ok);
    checks++;
    if (!ok || writeQ.size() != 4) begin
      errors++; $display("FAIL single_writes got=%0d want=4", writeQ.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (writeQ[k].d !== expD[k] || writeQ[k].x !== 8'(k) || writeQ[k].y !== 9'd0
            || writeQ[k].cyc != reqCyc + 3 + k) begin
          errors++;
          $display("FAIL single_pixel%0d got=%h x=%0d y=%0d cyc=%0d want=%h x=%0d y=0 cyc=%0d",
                   k, writeQ[k].d, writeQ[k].x, writeQ[k].y, writeQ[k].cyc, expD[k], k, reqCyc + 3 + k);
        end
      end
    end
    checks++;
    if (grantQ.size() < 1 || grantQ[0].cyc != reqCyc + 1) begin
      errors++; $display("FAIL single_grant_latency got=%0d want=%0d", grantQ.size() ? grantQ[0].cyc : -1, reqCyc + 1);
    end
    checks++;
    if (doneQ.size() != 1 || doneQ[0].vec !== 3'b001 || doneQ[0].cyc != reqCyc + 7) begin
      errors++; $display("FAIL single_done got=%0d want=%0d", doneQ.size() ? doneQ[0].cyc : -1, reqCyc + 7);
    end
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if ({busy, taskDone} !== 4'b0000) begin
      errors++; $display("FAIL single_idle got=%b want=0000", {busy, taskDone});
    end
  endtask

  task automatic test_stall();
    logic pat [4];
    int reqCyc;
    int expFwd [4];
    int expWr [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    doReset();
    taskReq = 3'b001;
    reqCyc = cyc;
    tick();
    taskReq = '0;
    tick();
    for (int k = 0; k < 12; k++) begin
      lcdPixelReady = pat[k % 4];
      tick();
    end
    lcdPixelReady = 1'b0;
    expFwd = '{reqCyc + 2, reqCyc + 5, reqCyc + 6, reqCyc + 9};
    expWr  = '{reqCyc + 3, reqCyc + 6, reqCyc + 7, reqCyc + 10};
    checks++;
    if (fwdQ.size() != 4) begin
      errors++; $display("FAIL stall_forward_count got=%0d want=4", fwdQ.size());
    end
    checks++;
    if (writeQ.size() != 4) begin
      errors++; $display("FAIL stall_write_count got=%0d want=4", writeQ.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < fwdQ.size() && k < writeQ.size()) begin
        checks++;
        if (fwdQ[k] != expFwd[k] || writeQ[k].cyc != expWr[k] || writeQ[k].x !== 8'(k)) begin
          errors++;
          $display("FAIL stall_pixel%0d got fwd=%0d wr=%0d x=%0d want fwd=%0d wr=%0d x=%0d",
                   k, fwdQ[k], writeQ[k].cyc, writeQ[k].x, expFwd[k], expWr[k], k);
        end
      end
    end
    checks++;
    if (doneQ.size() != 1 || doneQ[0].cyc != reqCyc + 11) begin
      errors++; $display("FAIL stall_done got=%0d want=%0d", doneQ.size() ? doneQ[0].cyc : -1, reqCyc + 11);
    end
  endtask

  task automatic test_round_robin();
    logic [NT-1:0] expV [4];
    int reqCyc;
    bit ok;
    expV = '{3'b001, 3'b010, 3'b100, 3'b001};
    doReset();
    lcdPixelReady = 1'b1;
    taskReq = 3'b111;
    reqCyc = cyc;
    waitQ(0, 4, 100, ok);
    tick();
    taskReq = '0;
    waitQ(2, 4, 40, ok);
    repeat (6) tick();
    checks++;
    if (!ok || grantQ.size() != 4) begin
      errors++; $display("FAIL rr_grant_count got=%0d want=4", grantQ.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grantQ[k].vec !== expV[k] || grantQ[k].cyc != reqCyc + 1 + 8 * k) begin
          errors++;
          $display("FAIL rr_grant%0d got=%b cyc=%0d want=%b cyc=%0d",
                   k, grantQ[k].vec, grantQ[k].cyc, expV[k], reqCyc + 1 + 8 * k);
        end
      end
    end
    checks++;
    if (writeQ.size() != 16 || writeQ[4].d !== 16'h2000 || writeQ[8].d !== 16'h3000) begin
      errors++; $display("FAIL rr_writes got=%0d want=16", writeQ.size());
    end
  endtask

  task automatic test_request_drop();
    bit ok;
    doReset();
    lcdPixelReady = 1'b1;
    taskReq = 3'b010;
    waitQ(1, 2, 20, ok);
    tick();
    taskReq = '0;
    waitQ(2, 1, 40, ok);
    repeat (10) tick();
    checks++;
    if (!ok || writeQ.size() != 4) begin
      errors++; $display("FAIL drop_writes got=%0d want=4", writeQ.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (writeQ[k].tsk !== 2'd1 || writeQ[k].d !== 16'(16'h2000 + k)
            || writeQ[k].x !== 8'(k) || writeQ[k].y !== 9'd1) begin
          errors++;
          $display("FAIL drop_pixel%0d got task=%0d d=%h x=%0d y=%0d want task=1 d=%h x=%0d y=1",
                   k, writeQ[k].tsk, writeQ[k].d, writeQ[k].x, writeQ[k].y, 16'(16'h2000 + k), k);
        end
      end
    end
    checks++;
    if (grantQ.size() != 1 || doneQ.size() != 1 || doneQ[0].vec !== 3'b010) begin
      errors++; $display("FAIL drop_no_regrant got grants=%0d dones=%0d want 1 1", grantQ.size(), doneQ.size());
    end
  endtask

  task automatic test_stale_end();
    int reqCyc;
    bit ok;
    doReset();
    lcdPixelReady = 1'b1;
    setStale = 3'b100;
    tick();
    setStale = '0;
    taskReq = 3'b100;
    reqCyc = cyc;
    tick();
    taskReq = '0;
    @(negedge clock);
    checks++;
    if (taskReset !== 3'b100) begin
      errors++; $display("FAIL stale_restart got=%b want=100", taskReset);
    end
    waitQ(2, 1, 40, ok);
    repeat (4) tick();
    checks++;
    if (!ok || writeQ.size() != 4 || writeQ[0].d !== 16'h3000 || writeQ[3].d !== 16'h3003) begin
      errors++; $display("FAIL stale_writes got=%0d want=4", writeQ.size());
    end
    checks++;
    if (doneQ.size() != 1 || doneQ[0].vec !== 3'b100 || doneQ[0].cyc != reqCyc + 7) begin
      errors++; $display("FAIL stale_done got=%0d want=1 at %0d", doneQ.size(), reqCyc + 7);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    doReset();
    frameLen[0] = 200;
    lcdPixelReady = 1'b1;
    taskReq = 3'b001;
    waitQ(1, 100, 300, ok);
    checks++;
    if (!ok || lcdPixelWrite !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_active got write=%b busy=%b want 1 1", lcdPixelWrite, busy);
    end
    #1 resetApp_n = 1'b0;
    #1;
    checks++;
    if ({taskPixelReady, lcdPixelWrite, busy, taskReset, taskDone} !== '0) begin
      errors++; $display("FAIL midrun_async_ctrl got=%b want=0",
                         {taskPixelReady, lcdPixelWrite, busy, taskReset, taskDone});
    end
    checks++;
    if ({lcdPixelData, lcdXAddr, lcdYAddr} !== '0) begin
      errors++; $display("FAIL midrun_async_mux got=%h want=0", {lcdPixelData, lcdXAddr, lcdYAddr});
    end
    frameLen[0] = 4;
    tick();
    grantQ.delete(); doneQ.delete(); writeQ.delete(); fwdQ.delete();
    resetApp_n = 1'b1;
    @(negedge clock);
    checks++;
    if (taskReset !== 3'b000) begin
      errors++; $display("FAIL midrun_regrant_early got=%b want=000", taskReset);
    end
    @(negedge clock);
    checks++;
    if (taskReset !== 3'b001) begin
      errors++; $display("FAIL midrun_regrant got=%b want=001", taskReset);
    end
    tick();
    taskReq = '0;
    waitQ(2, 1, 40, ok);
    checks++;
    if (!ok || writeQ.size() != 4) begin
      errors++; $display("FAIL midrun_rerun_writes got=%0d want=4", writeQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_round_robin();
    test_request_drop();
    test_stale_end();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
